cordic_req_sched: RTL and testbench

// Shares one iterative vectoring CORDIC engine (phase/magnitude, 16 iterations) between NUM_REQ requesters.

---
 rtl/cordic_pkg.sv | 15 +
 rtl/cordic_rr_arb.sv | 31 +++
 rtl/cordic_req_sched.sv | 138 +++++++++++++
 tb/tb_cordic_req_sched.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and state encoding for the CORDIC engine and its request scheduler.
package cordic_pkg;

  localparam int DATA_W   = 32;
  localparam int ANG_FRAC = 16;
  localparam int DEG_180  = 180;
  localparam int DEG_360  = 360;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/cordic_rr_arb.sv
// Combinational round-robin arbiter: search begins one past i_ptr and wraps.
module cordic_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);
  import cordic_pkg::*;

  logic [ID_W-1:0] w_k;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_k   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_k = ID_W'((int'(i_ptr) + i) % NUM_REQ);
      if (!o_any && i_req[w_k]) begin
        o_any = 1'b1;
        o_idx = w_k;
      end
    end
    o_gnt[o_idx] = o_any;
  end

endmodule

// File: rtl/cordic_req_sched.sv
// Shares one iterative vectoring CORDIC between NUM_REQ requesters, one job at a time,
// with round-robin grant and a per-job watchdog.
module cordic_req_sched #(
  parameter int  NUM_REQ = 4,
  parameter int  DATA_W  = cordic_pkg::DATA_W,
  parameter int  TIMEOUT = 64,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_x,
  input  logic [NUM_REQ*DATA_W-1:0] req_y,
  output logic                      eng_start,
  output logic [DATA_W-1:0]         eng_x,
  output logic [DATA_W-1:0]         eng_y,
  input  logic                      eng_valid,
  input  logic [DATA_W-1:0]         eng_phase,
  input  logic [DATA_W-1:0]         eng_mag,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_phase,
  output logic [DATA_W-1:0]         rsp_mag,
  output logic                      rsp_timeout
);
  import cordic_pkg::*;

  localparam int          WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t              r_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_eng_x;
  logic [DATA_W-1:0]   r_eng_y;
  logic                r_eng_start;
  logic [WD_W-1:0]     r_wd_cnt;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_phase;
  logic [DATA_W-1:0]   r_rsp_mag;
  logic                r_rsp_timeout;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]     w_gnt_idx;
  logic                w_gnt_any;
  logic                w_idle;
  logic                w_accept;
  logic [DATA_W-1:0]   w_sel_x;
  logic [DATA_W-1:0]   w_sel_y;

  cordic_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx),
    .o_any (w_gnt_any)
  );

  // Ready is withheld while reset is held so nothing is offered before the FSM runs.
  assign w_idle    = (r_state == ST_IDLE) && sys_rst;
  assign req_ready = w_idle ? w_gnt : '0;
  assign w_accept  = w_idle && w_gnt_any;
  assign w_sel_x   = req_x[int'(w_gnt_idx)*DATA_W +: DATA_W];
  assign w_sel_y   = req_y[int'(w_gnt_idx)*DATA_W +: DATA_W];

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= ID_W'(NUM_REQ - 1);
      r_id          <= '0;
      r_eng_x       <= '0;
      r_eng_y       <= '0;
      r_eng_start   <= 1'b0;
      r_wd_cnt      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_phase   <= '0;
      r_rsp_mag     <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_eng_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_eng_x     <= w_sel_x;
            r_eng_y     <= w_sel_y;
            r_id        <= w_gnt_idx;
            r_eng_start <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_wd_cnt <= '0;
          r_state  <= ST_WAIT;
        end
        ST_WAIT: begin
          r_wd_cnt <= r_wd_cnt + WD_W'(1);
          // A result arriving on the watchdog's last cycle still counts as a result.
          if (eng_valid) begin
            r_rsp_phase   <= eng_phase;
            r_rsp_mag     <= eng_mag;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= ST_RESP;
          end else if (r_wd_cnt == WD_LAST) begin
            r_rsp_phase   <= '0;
            r_rsp_mag     <= '0;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rr_ptr    <= r_id;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign eng_start   = r_eng_start;
  assign eng_x       = r_eng_x;
  assign eng_y       = r_eng_y;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_id;
  assign rsp_phase   = r_rsp_phase;
  assign rsp_mag     = r_rsp_mag;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_cordic_req_sched.sv
// Scoreboard bench for cordic_req_sched with a behavioural CORDIC engine and requester drivers.
module tb_cordic_req_sched;
  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int TO  = 64;
  localparam int LAT = 18;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b0;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_x;
  logic [NR*DW-1:0]  req_y;
  logic              eng_start;
  logic [DW-1:0]     eng_x;
  logic [DW-1:0]     eng_y;
  logic              eng_valid;
  logic [DW-1:0]     eng_phase;
  logic [DW-1:0]     eng_mag;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [DW-1:0]     rsp_phase;
  logic [DW-1:0]     rsp_mag;
  logic              rsp_timeout;

  cordic_req_sched #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x       (req_x),
    .req_y       (req_y),
    .eng_start   (eng_start),
    .eng_x       (eng_x),
    .eng_y       (eng_y),
    .eng_valid   (eng_valid),
    .eng_phase   (eng_phase),
    .eng_mag     (eng_mag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_phase   (rsp_phase),
    .rsp_mag     (rsp_mag),
    .rsp_timeout (rsp_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", tag, obs, obs, exp, exp, cyc);
    end
  endtask

  function automatic logic [31:0] q16(input int v);
    return 32'(v <<< 16);
  endfunction

  function automatic logic [31:0] ref_phase(input logic [31:0] x, input logic [31:0] y);
    real a;
    int  d;
    a = $atan2($itor($signed(y)), $itor($signed(x))) * 180.0 / 3.14159265358979;
    if (a < 0.0) a = a + 360.0;
    d = int'(a);
    return 32'(d);
  endfunction

  function automatic logic [31:0] ref_mag(input logic [31:0] x, input logic [31:0] y);
    real xr, yr, m;
    xr = $itor($signed(x));
    yr = $itor($signed(y));
    m  = $sqrt(xr * xr + yr * yr);
    return 32'(longint'(m));
  endfunction

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] ph;
    logic [31:0] mg;
    logic        to;
  } exp_t;
  exp_t sb[$];

  task automatic exp_push(input int id, input logic [31:0] x, input logic [31:0] y, input bit to);
    exp_t e;
    e.id = 2'(id);
    e.to = to;
    e.ph = to ? 32'd0 : ref_phase(x, y);
    e.mg = to ? 32'd0 : ref_mag(x, y);
    sb.push_back(e);
  endtask

  // Per-requester job lists; only the requester driver touches req_* signals.
  logic [31:0] jx[NR][8];
  logic [31:0] jy[NR][8];
  int          jn[NR] = '{default: 0};
  int          jp[NR] = '{default: 0};

  task automatic add_job(input int r, input logic [31:0] x, input logic [31:0] y);
    jx[r][jn[r]] = x;
    jy[r][jn[r]] = y;
    jn[r]++;
  endtask

  initial begin
    logic [NR-1:0] hs;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    forever begin
      @(negedge sys_clk);
      hs = req_valid & req_ready;
      @(posedge sys_clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (hs[i]) begin
          req_valid[i] = 1'b0;
          jp[i]++;
        end
        if (!req_valid[i] && jp[i] < jn[i]) begin
          req_x[i*DW +: DW] = jx[i][jp[i]];
          req_y[i*DW +: DW] = jy[i][jp[i]];
          req_valid[i]      = 1'b1;
        end
      end
    end
  end

  // Engine model: answers eng_start after eng_lat cycles (0 = never), drops the job on reset.
  int eng_lat  = LAT;
  int poke_cnt = 0;
  initial begin
    int          seen;
    logic [31:0] lx, ly;
    bit          ab;
    seen      = 0;
    eng_valid = 1'b0;
    eng_phase = '0;
    eng_mag   = '0;
    forever begin
      @(negedge sys_clk);
      if (poke_cnt != seen) begin
        seen = poke_cnt;
        @(posedge sys_clk);
        #1;
        eng_valid = 1'b1;
        eng_phase = 32'd77;
        eng_mag   = 32'd999;
        @(posedge sys_clk);
        #1;
        eng_valid = 1'b0;
      end else if (eng_start && eng_lat > 0) begin
        lx = eng_x;
        ly = eng_y;
        ab = 1'b0;
        for (int k = 0; k < eng_lat; k++) begin
          @(posedge sys_clk);
          #1;
          if (!sys_rst) begin
            ab = 1'b1;
            break;
          end
        end
        if (!ab) begin
          eng_valid = 1'b1;
          eng_phase = ref_phase(lx, ly);
          eng_mag   = ref_mag(lx, ly);
          @(posedge sys_clk);
          #1;
          eng_valid = 1'b0;
        end
      end
    end
  end

  int acc_cyc   = 0;
  int start_cyc = 0;
  int n_start   = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (req_ready != '0) begin
        chk_eq("ready_onehot", 64'($countones(req_ready)), 64'd1);
        if ((req_valid & req_ready) != '0) acc_cyc = cyc;
      end
      if (eng_start) begin
        n_start++;
        start_cyc = cyc;
      end
      if (rsp_valid && rsp_ready) begin
        chk_eq("rsp_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk_eq("rsp_id", 64'(rsp_id), 64'(e.id));
          chk_eq("rsp_phase", 64'(rsp_phase), 64'(e.ph));
          chk_eq("rsp_mag", 64'(rsp_mag), 64'(e.mg));
          chk_eq("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
        end
      end
    end
  end

  int rsp_cyc = 0;

  task automatic wait_rsp(input int max);
    int k;
    k = 0;
    @(negedge sys_clk);
    while (!rsp_valid && k < max) begin
      @(negedge sys_clk);
      k++;
    end
    rsp_cyc = cyc;
    chk_eq("wait_rsp", 64'(rsp_valid), 64'd1);
  endtask

  task automatic wait_start(input int max);
    int k;
    k = 0;
    @(negedge sys_clk);
    while (!eng_start && k < max) begin
      @(negedge sys_clk);
      k++;
    end
    chk_eq("wait_start", 64'(eng_start), 64'd1);
  endtask

  task automatic drain(input int max);
    int k;
    k = 0;
    @(negedge sys_clk);
    while ((sb.size() != 0 || rsp_valid) && k < max) begin
      @(negedge sys_clk);
      k++;
    end
    chk_eq("drain", 64'(sb.size()), 64'd0);
    @(negedge sys_clk);
  endtask

  task automatic do_reset();
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk_eq({pfx, "_req_ready"}, 64'(req_ready), 64'd0);
    chk_eq({pfx, "_eng_start"}, 64'(eng_start), 64'd0);
    chk_eq({pfx, "_eng_x"}, 64'(eng_x), 64'd0);
    chk_eq({pfx, "_eng_y"}, 64'(eng_y), 64'd0);
    chk_eq({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk_eq({pfx, "_rsp_id"}, 64'(rsp_id), 64'd0);
    chk_eq({pfx, "_rsp_phase"}, 64'(rsp_phase), 64'd0);
    chk_eq({pfx, "_rsp_mag"}, 64'(rsp_mag), 64'd0);
    chk_eq({pfx, "_rsp_timeout"}, 64'(rsp_timeout), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int          n0;
    logic [31:0] bx, by;
    rsp_ready = 1'b1;
    sys_rst   = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk_all_zero("reset");
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;

    // Single request from requester 2: 3-4-5 triangle
    n0 = n_start;
    exp_push(2, q16(3), q16(4), 1'b0);
    add_job(2, q16(3), q16(4));
    wait_rsp(100);
    chk_eq("single_phase53", 64'(rsp_phase), 64'd53);
    chk_eq("single_mag5", 64'(rsp_mag), 64'(q16(5)));
    chk_eq("single_start_lat", 64'(start_cyc - acc_cyc), 64'd1);
    chk_eq("single_rsp_lat", 64'(rsp_cyc - acc_cyc), 64'd20);
    drain(100);
    chk_eq("single_nstart", 64'(n_start - n0), 64'd1);

    // All four requesters valid after reset: order 0,1,2,3,0
    do_reset();
    exp_push(0, q16(1), q16(1), 1'b0);
    exp_push(1, q16(-2), q16(1), 1'b0);
    exp_push(2, q16(0), q16(3), 1'b0);
    exp_push(3, q16(5), q16(-5), 1'b0);
    exp_push(0, q16(-1), q16(-3), 1'b0);
    add_job(0, q16(1), q16(1));
    add_job(0, q16(-1), q16(-3));
    add_job(1, q16(-2), q16(1));
    add_job(2, q16(0), q16(3));
    add_job(3, q16(5), q16(-5));
    drain(400);

    // Backpressure on the response port
    rsp_ready = 1'b0;
    bx = q16(7);
    by = q16(2);
    exp_push(1, bx, by, 1'b0);
    add_job(1, bx, by);
    wait_rsp(100);
    exp_push(0, q16(2), q16(9), 1'b0);
    add_job(0, q16(2), q16(9));
    repeat (10) begin
      @(negedge sys_clk);
      chk_eq("bp_valid", 64'(rsp_valid), 64'd1);
      chk_eq("bp_id", 64'(rsp_id), 64'd1);
      chk_eq("bp_phase", 64'(rsp_phase), 64'(ref_phase(bx, by)));
      chk_eq("bp_mag", 64'(rsp_mag), 64'(ref_mag(bx, by)));
      chk_eq("bp_no_ready", 64'(req_ready), 64'd0);
    end
    @(posedge sys_clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk_eq("bp_idle_grant", 64'(req_ready), 64'h1);
    chk_eq("bp_valid_drop", 64'(rsp_valid), 64'd0);
    drain(100);

    // Watchdog: engine never answers; WAIT lasts TO cycles after the eng_start cycle
    eng_lat = 0;
    exp_push(2, q16(5), q16(-1), 1'b1);
    add_job(2, q16(5), q16(-1));
    wait_start(100);
    @(negedge sys_clk);
    chk_eq("to_eng_x_held", 64'(eng_x), 64'(q16(5)));
    chk_eq("to_eng_y_held", 64'(eng_y), 64'(q16(-1)));
    wait_rsp(TO + 20);
    chk_eq("to_flag", 64'(rsp_timeout), 64'd1);
    chk_eq("to_lat", 64'(rsp_cyc - start_cyc), 64'(TO + 1));
    drain(50);
    eng_lat = LAT;
    poke_cnt++;
    repeat (5) begin
      @(negedge sys_clk);
      chk_eq("late_ignored", 64'(rsp_valid), 64'd0);
    end
    exp_push(1, q16(-4), q16(4), 1'b0);
    add_job(1, q16(-4), q16(4));
    drain(100);

    // Engine result on the watchdog's final cycle wins
    eng_lat = TO;
    exp_push(0, q16(6), q16(8), 1'b0);
    add_job(0, q16(6), q16(8));
    wait_rsp(TO + 20);
    chk_eq("col_timeout", 64'(rsp_timeout), 64'd0);
    chk_eq("col_lat", 64'(rsp_cyc - start_cyc), 64'(TO + 1));
    drain(50);
    eng_lat = LAT;

    // Reset while waiting on the engine: job dropped, requester 3 served afterwards
    add_job(3, q16(2), q16(2));
    wait_start(100);
    repeat (5) @(negedge sys_clk);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    exp_push(3, q16(-3), q16(3), 1'b0);
    add_job(3, q16(-3), q16(3));
    @(negedge sys_clk);
    chk_all_zero("midrst");
    repeat (3) begin
      @(negedge sys_clk);
      chk_eq("midrst_no_rsp", 64'(rsp_valid), 64'd0);
      chk_eq("midrst_no_ready", 64'(req_ready), 64'd0);
    end
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk_eq("midrst_grant3", 64'(req_ready), 64'h8);
    drain(100);

    chk_eq("sb_final_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
